spi_read_sequencer: RTL and testbench
=====================================

# spi_read_sequencer

Command-level sequencer directly upstream of the SPI byte engine (`spi_interface`). It turns a single read request (start address and byte count) into a standard serial-flash READ transaction: opcode, then address bytes, then N data bytes. It drives the engine's `enabled`, `data_in` and `continue_read` inputs, and returns each received byte to the consumer over a valid/ready handshake. The engine's bit-level timing (CPOL=0, CPHA=0, 4 clk_in per bit) is unchanged; this block only sequences bytes.

## Interface
- `READ_CMD`, 8'h03: opcode sent as the first byte.
- `ADDR_BYTES`, 3: number of address bytes, MSB first, range 1..4.
- `CS_HIGH_CYCLES`, 4: minimum clk_in cycles `enabled` stays low after a transaction.
- `clk_in` in 1: system clock; shared with the byte engine.
- `reset` in 1: asynchronous, active-high reset.
- `rd_start` in 1: one-cycle request strobe; sampled only in IDLE.
- `rd_addr` in 32: start address; the low `ADDR_BYTES*8` bits are used, latched on `rd_start`.
- `rd_len` in 16: number of data bytes, latched on `rd_start`.
- `rd_busy` out 1: high from the accepted `rd_start` until `rd_done`.
- `rd_data` out 8: received byte; stable while `rd_valid`=1.
- `rd_valid` out 1: byte available.
- `rd_ready` in 1: consumer accepts the byte when `rd_valid`&&`rd_ready`.
- `rd_done` out 1: one-cycle pulse at the end of the transaction.
- `spi_enabled` out 1: to engine `enabled`.
- `spi_data_in` out 8: to engine `data_in`.
- `spi_continue_read` out 1: to engine `continue_read`.
- `spi_data_out` in 8: from engine `data_out`.
- `spi_stage` in 8: from engine `spi_stage`; value 99 = byte complete.

## Operation
- Reset values: `rd_busy`=0, `rd_valid`=0, `rd_done`=0, `rd_data`=0, `spi_enabled`=0, `spi_data_in`=8'hFF, `spi_continue_read`=0. State is IDLE.
- **IDLE:** on `rd_start`:
  - If `rd_len`==0: pulse `rd_done` next cycle. The engine is never enabled.
  - Otherwise: latch address and length, load `spi_data_in`=READ_CMD, set `spi_enabled`=1 and `rd_busy`=1. Go to SETTLE.
- **SETTLE:** spans 2 cycles.
  - Ignore `spi_stage` during these cycles, because the engine still shows the previous 99 or 0.
  - `spi_continue_read` returns to 0 in the first SETTLE cycle.
  - Then go to WAIT.
- **WAIT:** stay until `spi_stage`==99.
  - Command or address phase: go to NEXT.
  - Data phase: capture `rd_data`<=`spi_data_out`, set `rd_valid`=1, go to HOLD.
- **NEXT:**
  - Set `spi_data_in` to the next byte: address MSB first, then 8'hFF dummy during data reads.
  - Assert `spi_continue_read`=1 for exactly one cycle.
  - Go to SETTLE.
- **HOLD:** wait for `rd_ready`.
  - On handshake, clear `rd_valid` and decrement the remaining count.
  - If remaining > 0, go to NEXT. Otherwise go to CSHI.
- **CSHI:**
  - `spi_enabled`=0 for CS_HIGH_CYCLES cycles.
  - Then pulse `rd_done`, clear `rd_busy`, return to IDLE.
- Counters: the byte counter is 16-bit and never wraps; `rd_len`=16'hFFFF transfers 65535 bytes. The address-byte index is 2-bit.
- `rd_start` while `rd_busy`=1 is ignored. It has no effect on the latched request.
- Reset mid-transaction: all outputs return to reset values immediately. `spi_enabled`=0 forces the engine to release CS on its next clock. Any partial byte is discarded.
- `rd_ready` held high: there are no stall cycles in HOLD beyond the single handshake cycle.

## Timing
- `rd_start` to `spi_enabled`=1: 1 cycle.
- Each byte: about 33 engine cycles (8 bits × 4 stages + 1), plus 2 SETTLE cycles and 1 NEXT cycle.
- `rd_valid` rises 1 cycle after `spi_stage`==99 is seen in WAIT.
- Last handshake to `rd_done`: CS_HIGH_CYCLES+1 cycles.
- `spi_continue_read` is always a single-cycle pulse, so each pulse is a fresh rising edge at the engine.
- `spi_data_in` is stable from NEXT until the next WAIT exit.

## Structure
- Shared package holds:
  - The state enum: IDLE, SETTLE, WAIT, NEXT, HOLD, CSHI.
  - `SPI_STAGE_DONE`=8'd99.
  - `SPI_DUMMY_BYTE`=8'hFF.
- No sub-module. The bench instantiates this block together with `spi_interface` and a SPI flash model.

## Test plan
- Request addr=0x012345, len=4; flash returns 0xA0..0xA3. Required: MOSI carries 03 01 23 45 FF FF FF FF; `rd_data` sequence is A0 A1 A2 A3; one `rd_done` pulse.
- Same transfer with `rd_ready` low for 10 cycles on byte 2. Required: `rd_valid` and `rd_data` hold; SCK stays idle; no byte is lost or duplicated.
- Request len=0. Required: `rd_done` 1 cycle after `rd_start`; CS never falls.
- Second `rd_start` during a busy transfer. Required: ignored; the first transfer completes unchanged.
- Assert `reset` during address byte 2. Required: `spi_enabled`=0 in the same cycle; CS high next clock; a new request then completes normally.
- Two back-to-back requests. Required: CS is high for at least CS_HIGH_CYCLES between them; each transaction starts with opcode 03.

Source files
------------

// File: rtl/spi_read_sequencer_pkg.sv
// Shared types and constants for the serial-flash READ sequencer.
// Holds the FSM state set, the kind of byte on the wire, and the address-byte selector.
package spi_read_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CSHI   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    BYTE_CMD  = 2'd0,
    BYTE_ADDR = 2'd1,
    BYTE_DATA = 2'd2
  } byte_kind_t;

  localparam logic [7:0] SPI_STAGE_DONE = 8'd99;
  localparam logic [7:0] SPI_DUMMY_BYTE = 8'hFF;

  // Byte idx of the latched address, idx 0 being the least significant.
  function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] idx);
    logic [7:0] res;
    case (idx)
      2'd0:    res = addr[7:0];
      2'd1:    res = addr[15:8];
      2'd2:    res = addr[23:16];
      2'd3:    res = addr[31:24];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_read_sequencer.sv
// Turns one read request into opcode + address + N data bytes on the SPI byte engine,
// handing each received byte to the consumer over a valid/ready handshake.
module spi_read_sequencer
  import spi_read_sequencer_pkg::*;
#(
  parameter logic [7:0]  READ_CMD       = 8'h03,
  parameter int unsigned ADDR_BYTES     = 3,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        rd_start,
  input  logic [31:0] rd_addr,
  input  logic [15:0] rd_len,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_done,
  output logic        spi_enabled,
  output logic [7:0]  spi_data_in,
  output logic        spi_continue_read,
  input  logic [7:0]  spi_data_out,
  input  logic [7:0]  spi_stage
);

  localparam logic [1:0] ADDR_MSB_IDX = 2'(ADDR_BYTES - 1);
  localparam logic [7:0] CS_LAST      = 8'(CS_HIGH_CYCLES - 1);

  seq_state_t  state_r,     state_s;
  byte_kind_t  kind_r,      kind_s;
  logic        settle_r,    settle_s;
  logic [1:0]  addr_idx_r,  addr_idx_s;
  logic [31:0] addr_r,      addr_s;
  logic [15:0] remaining_r, remaining_s;
  logic [7:0]  cs_cnt_r,    cs_cnt_s;
  logic        rd_busy_r,   rd_busy_s;
  logic [7:0]  rd_data_r,   rd_data_s;
  logic        rd_valid_r,  rd_valid_s;
  logic        rd_done_r,   rd_done_s;
  logic        spi_en_r,    spi_en_s;
  logic [7:0]  spi_din_r,   spi_din_s;
  logic        spi_cont_r,  spi_cont_s;

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_s     = state_r;
    kind_s      = kind_r;
    settle_s    = settle_r;
    addr_idx_s  = addr_idx_r;
    addr_s      = addr_r;
    remaining_s = remaining_r;
    cs_cnt_s    = cs_cnt_r;
    rd_busy_s   = rd_busy_r;
    rd_data_s   = rd_data_r;
    rd_valid_s  = rd_valid_r;
    rd_done_s   = 1'b0;
    spi_en_s    = spi_en_r;
    spi_din_s   = spi_din_r;
    spi_cont_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (rd_start) begin
          if (rd_len == 16'd0) begin
            rd_done_s = 1'b1;
          end else begin
            addr_s      = rd_addr;
            remaining_s = rd_len;
            kind_s      = BYTE_CMD;
            spi_din_s   = READ_CMD;
            spi_en_s    = 1'b1;
            rd_busy_s   = 1'b1;
            settle_s    = 1'b0;
            state_s     = ST_SETTLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      // The engine still shows the previous stage value here, so it is not looked at.
      ST_SETTLE: begin
        if (settle_r == 1'b0) begin
          settle_s = 1'b1;
        end else begin
          settle_s = 1'b0;
          state_s  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (spi_stage == SPI_STAGE_DONE) begin
          if (kind_r == BYTE_DATA) begin
            rd_data_s  = spi_data_out;
            rd_valid_s = 1'b1;
            state_s    = ST_HOLD;
          end else begin
            state_s = ST_NEXT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_NEXT: begin
        case (kind_r)
          BYTE_CMD: begin
            kind_s     = BYTE_ADDR;
            addr_idx_s = ADDR_MSB_IDX;
            spi_din_s  = addr_byte(addr_r, ADDR_MSB_IDX);
          end
          BYTE_ADDR: begin
            if (addr_idx_r != 2'd0) begin
              addr_idx_s = addr_idx_r - 2'd1;
              spi_din_s  = addr_byte(addr_r, addr_idx_r - 2'd1);
            end else begin
              kind_s    = BYTE_DATA;
              spi_din_s = SPI_DUMMY_BYTE;
            end
          end
          default: begin
            spi_din_s = SPI_DUMMY_BYTE;
          end
        endcase
        spi_cont_s = 1'b1;
        settle_s   = 1'b0;
        state_s    = ST_SETTLE;
      end

      ST_HOLD: begin
        if (rd_ready) begin
          rd_valid_s  = 1'b0;
          remaining_s = remaining_r - 16'd1;
          if (remaining_r > 16'd1) begin
            state_s = ST_NEXT;
          end else begin
            spi_en_s = 1'b0;
            cs_cnt_s = 8'd0;
            state_s  = ST_CSHI;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end

      ST_CSHI: begin
        if (cs_cnt_r == CS_LAST) begin
          rd_done_s = 1'b1;
          rd_busy_s = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          cs_cnt_s = cs_cnt_r + 8'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the engine off and discards any partial byte.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      kind_r      <= BYTE_CMD;
      settle_r    <= 1'b0;
      addr_idx_r  <= 2'd0;
      addr_r      <= 32'd0;
      remaining_r <= 16'd0;
      cs_cnt_r    <= 8'd0;
      rd_busy_r   <= 1'b0;
      rd_data_r   <= 8'd0;
      rd_valid_r  <= 1'b0;
      rd_done_r   <= 1'b0;
      spi_en_r    <= 1'b0;
      spi_din_r   <= SPI_DUMMY_BYTE;
      spi_cont_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      kind_r      <= kind_s;
      settle_r    <= settle_s;
      addr_idx_r  <= addr_idx_s;
      addr_r      <= addr_s;
      remaining_r <= remaining_s;
      cs_cnt_r    <= cs_cnt_s;
      rd_busy_r   <= rd_busy_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
      rd_done_r   <= rd_done_s;
      spi_en_r    <= spi_en_s;
      spi_din_r   <= spi_din_s;
      spi_cont_r  <= spi_cont_s;
    end
  end

  assign rd_busy           = rd_busy_r;
  assign rd_data           = rd_data_r;
  assign rd_valid          = rd_valid_r;
  assign rd_done           = rd_done_r;
  assign spi_enabled       = spi_en_r;
  assign spi_data_in       = spi_din_r;
  assign spi_continue_read = spi_cont_r;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Bench: sequencer driving a behavioural byte engine and serial-flash model,
// with a queue scoreboard for MOSI bytes, returned data and done pulses.
module tb_spi_read_sequencer;

  localparam int CS_HIGH = 4;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        rd_start = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic [15:0] rd_len = 16'd0;
  logic        rd_ready = 1'b0;
  logic        rd_busy, rd_valid, rd_done;
  logic [7:0]  rd_data;
  logic        spi_enabled, spi_continue_read;
  logic [7:0]  spi_data_in, spi_data_out, spi_stage;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_seen = 0;
  int ready_mode = 0;
  logic ready_manual = 1'b0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_data[$];
  logic [7:0] mosi_seen[$];
  logic [7:0] sess[$];

  logic [7:0] eng_stage = 8'd0;
  logic [7:0] eng_tx = 8'd0;
  logic [7:0] eng_data_out = 8'd0;
  logic       eng_cs = 1'b1;
  logic       eng_cont_prev = 1'b0;
  int         eng_nbytes = 0;

  assign spi_stage    = eng_stage;
  assign spi_data_out = eng_data_out;

  always #5 clk_in = ~clk_in;

  spi_read_sequencer dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .rd_start          (rd_start),
    .rd_addr           (rd_addr),
    .rd_len            (rd_len),
    .rd_busy           (rd_busy),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_done           (rd_done),
    .spi_enabled       (spi_enabled),
    .spi_data_in       (spi_data_in),
    .spi_continue_read (spi_continue_read),
    .spi_data_out      (spi_data_out),
    .spi_stage         (spi_stage)
  );

  // Flash memory contents: a fixed function of the 24-bit byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] + a[15:8] + a[23:16] + 8'h37;
  endfunction

  // Flash reply for the byte now completing, decoded from the bytes already received this CS session.
  function automatic logic [7:0] flash_resp();
    int k;
    logic [23:0] base;
    k = sess.size();
    if (k >= 4 && sess[0] == 8'h03) begin
      base = {sess[1], sess[2], sess[3]};
      return flash_byte(base + 24'(k - 4));
    end
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte engine: 32 bit stages then 99, restarts on a continue_read rising edge, releases CS when disabled.
  always @(posedge clk_in) begin
    eng_cont_prev <= spi_continue_read;
    if (!spi_enabled) begin
      eng_stage  <= 8'd0;
      eng_cs     <= 1'b1;
      eng_nbytes <= 0;
      sess.delete();
    end else if (eng_stage == 8'd0 ||
                 (eng_stage == 8'd99 && spi_continue_read && !eng_cont_prev)) begin
      eng_stage  <= 8'd1;
      eng_cs     <= 1'b0;
      eng_tx     <= spi_data_in;
      eng_nbytes <= eng_nbytes + 1;
      mosi_seen.push_back(spi_data_in);
    end else if (eng_stage >= 8'd1 && eng_stage < 8'd32) begin
      eng_stage <= eng_stage + 8'd1;
    end else if (eng_stage == 8'd32) begin
      eng_stage    <= 8'd99;
      eng_data_out <= flash_resp();
      sess.push_back(eng_tx);
    end
  end

  // Consumer ready, changed shortly after each rising edge.
  always @(posedge clk_in) begin
    #2;
    case (ready_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = 1'($urandom_range(0, 1));
      default: rd_ready = ready_manual;
    endcase
  end

  // Scoreboard monitor: MOSI bytes, accepted data bytes, done pulses, CS-high gaps.
  logic prev_cs = 1'b1;
  int   high_run = 0;
  bit   had_session = 1'b0;
  always @(negedge clk_in) begin
    while (mosi_seen.size() > 0) begin
      logic [7:0] got;
      got = mosi_seen.pop_front();
      if (exp_mosi.size() == 0) begin
        checks++; errors++;
        $display("FAIL mosi_extra: got %0h, expected no byte", got);
      end else begin
        check("mosi_byte", 32'(got), 32'(exp_mosi.pop_front()));
      end
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data_extra: got %0h, expected no byte", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_data.pop_front()));
      end
    end
    if (rd_done === 1'b1) done_seen++;
    if (eng_cs) begin
      high_run++;
    end else begin
      if (prev_cs && had_session) check("cs_high_gap_ok", 32'(high_run >= CS_HIGH), 32'd1);
      had_session = 1'b1;
      high_run = 0;
    end
    prev_cs = eng_cs;
  end

  task automatic issue(input logic [31:0] addr, input logic [15:0] len, input bit expect_it);
    if (expect_it) begin
      exp_done++;
      if (len != 16'd0) begin
        exp_mosi.push_back(8'h03);
        exp_mosi.push_back(addr[23:16]);
        exp_mosi.push_back(addr[15:8]);
        exp_mosi.push_back(addr[7:0]);
        for (int i = 0; i < int'(len); i++) begin
          exp_mosi.push_back(8'hFF);
          exp_data.push_back(flash_byte(addr[23:0] + 24'(i)));
        end
      end
    end
    rd_addr  = addr;
    rd_len   = len;
    rd_start = 1'b1;
    @(negedge clk_in);
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (rd_done !== 1'b1 && n < 4000) begin
      @(negedge clk_in);
      n++;
    end
    check({name, "_done_in_time"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (rd_valid !== 1'b1 && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    check("valid_in_time", 32'(n < 500), 32'd1);
  endtask

  initial begin
    logic [7:0] held;
    bit stable_ok;
    bit cs_fell;
    int n;

    repeat (3) @(negedge clk_in);
    check("rst_busy",  32'(rd_busy), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_done",  32'(rd_done), 32'd0);
    check("rst_data",  32'(rd_data), 32'd0);
    check("rst_en",    32'(spi_enabled), 32'd0);
    check("rst_din",   32'(spi_data_in), 32'hFF);
    check("rst_cont",  32'(spi_continue_read), 32'd0);
    reset = 1'b0;
    @(negedge clk_in);

    // Basic read, consumer always ready.
    ready_mode = 0;
    issue(32'h0001_2345, 16'd4, 1'b1);
    check("start_en_latency", 32'(spi_enabled), 32'd1);
    check("start_busy", 32'(rd_busy), 32'd1);
    wait_done("basic");

    // Same read, byte 2 held off for 10 cycles.
    ready_mode = 2;
    ready_manual = 1'b0;
    @(negedge clk_in);
    issue(32'h0001_2345, 16'd4, 1'b1);
    for (int b = 0; b < 4; b++) begin
      wait_valid();
      if (b == 1) begin
        held = rd_data;
        stable_ok = 1'b1;
        repeat (10) begin
          @(negedge clk_in);
          if (!(rd_valid && rd_data == held && eng_stage == 8'd99 && !eng_cs)) stable_ok = 1'b0;
        end
        check("hold_stable", 32'(stable_ok), 32'd1);
      end
      ready_manual = 1'b1;
      @(negedge clk_in);
      ready_manual = 1'b0;
      @(negedge clk_in);
    end
    wait_done("hold");
    ready_mode = 0;
    @(negedge clk_in);

    // Zero-length request: done next cycle, CS untouched.
    issue(32'h00AA_5500, 16'd0, 1'b1);
    check("len0_done_next", 32'(rd_done), 32'd1);
    check("len0_not_busy", 32'(rd_busy), 32'd0);
    cs_fell = 1'b0;
    repeat (12) begin
      @(negedge clk_in);
      if (!eng_cs) cs_fell = 1'b1;
    end
    check("len0_cs_high", 32'(cs_fell), 32'd0);

    // A second start while busy is ignored.
    issue(32'h00AB_CDEF, 16'd3, 1'b1);
    repeat (40) @(negedge clk_in);
    issue(32'h0011_2233, 16'd5, 1'b0);
    wait_done("busy_ignore");
    repeat (20) @(negedge clk_in);
    check("busy_ignore_idle_cs", 32'(eng_cs), 32'd1);
    check("busy_ignore_idle_busy", 32'(rd_busy), 32'd0);

    // Reset during address byte 2, then a normal read.
    issue(32'h00C0_FFEE, 16'd2, 1'b1);
    n = 0;
    while (eng_nbytes != 3 && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    check("addr2_reached", 32'(n < 500), 32'd1);
    repeat (8) @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("mid_rst_en", 32'(spi_enabled), 32'd0);
    check("mid_rst_busy", 32'(rd_busy), 32'd0);
    check("mid_rst_din", 32'(spi_data_in), 32'hFF);
    check("mid_rst_cont", 32'(spi_continue_read), 32'd0);
    @(posedge clk_in);
    #1;
    check("mid_rst_cs_released", 32'(eng_cs), 32'd1);
    exp_mosi.delete();
    exp_data.delete();
    mosi_seen.delete();
    exp_done--;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    issue(32'h0012_3456, 16'd3, 1'b1);
    wait_done("after_reset");

    // Back-to-back requests.
    issue(32'h0000_0010, 16'd2, 1'b1);
    wait_done("b2b_first");
    issue(32'h00FF_FFFE, 16'd3, 1'b1);
    wait_done("b2b_second");

    // Randomised requests with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      logic [31:0] a;
      logic [15:0] l;
      a = $urandom;
      l = (t == 3) ? 16'd0 : 16'($urandom_range(1, 5));
      @(negedge clk_in);
      issue(a, l, 1'b1);
      wait_done("random");
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
    end
    ready_mode = 0;

    repeat (10) @(negedge clk_in);
    check("exp_data_drained", 32'(exp_data.size()), 32'd0);
    check("exp_mosi_drained", 32'(exp_mosi.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
